// File: rtl/llr_min_search.sv
// llr_min_search
//   Max-log LLR stage fed by the metric calculation array. One frame of up
//   to sym_num unsigned symbol metrics is captured together with a mode
//   code. The metrics are then swept LANES at a time. For every bit
//   position the block tracks the smallest metric among symbols whose label
//   bit is 0 (min0) and among those whose label bit is 1 (min1). It then
//   emits LLR_k = min1_k - min0_k.
//
//   Optional build macro: LLR_CLIP_EN
//     defined   -> each LLR is saturated to [-LLR_CLIP, +LLR_CLIP]
//     undefined -> full LLR_wordlength difference, LLR_CLIP unused
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   in_valid    in   frame present on metric_bus / mode
//   in_ready    out  block can accept a frame (low while rst_n is low)
//   mode        in   0=QPSK 1=8PSK 2=16APSK 3=32APSK 4..7=64APSK
//   metric_bus  in   metric of symbol i at [i*wordlength +: wordlength]
//   out_valid   out  llr_bus holds a result
//   out_ready   in   consumer accepts the result
//   llr_bus     out  LLR of bit k at [k*LLR_wordlength +: LLR_wordlength]
//   busy        out  high while sweeping or holding a result
module llr_min_search #(
    parameter int wordlength     = 18,
    parameter int LLR_wordlength = 19,
    parameter int sym_num        = 64,
    parameter int bit_num        = 6,
    parameter int LANES          = 8,
    parameter int LLR_CLIP       = 65535
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [2:0]                          mode,
    input  logic [sym_num*wordlength-1:0]       metric_bus,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [bit_num*LLR_wordlength-1:0]   llr_bus,
    output logic                                busy
);

    localparam int SW    = $clog2(sym_num);
    localparam int SYM_W = SW + 1;
    localparam int CNT_W = $clog2(sym_num / LANES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [wordlength-1:0] MIN_INIT = {wordlength{1'b1}};

`ifdef LLR_CLIP_EN
    localparam logic signed [LLR_wordlength-1:0] CLIP_POS = LLR_wordlength'(LLR_CLIP);
    localparam logic signed [LLR_wordlength-1:0] CLIP_NEG = -CLIP_POS;
`endif

    // Reject parameter sets that could overflow the LLR or leave a partial group.
    if (LLR_wordlength < wordlength + 1 || (sym_num % LANES) != 0 ||
        LLR_CLIP < 1 || LLR_CLIP >= 2 ** (LLR_wordlength - 1)) begin : g_bad_cfg
        $error("llr_min_search: inconsistent parameter set");
    end

    logic [1:0]                        state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [2:0]                        mode_q, mode_d;
    logic                              out_valid_q, out_valid_d;
    logic [wordlength-1:0]             metric_q [sym_num];
    logic [wordlength-1:0]             min0_q [bit_num];
    logic [wordlength-1:0]             min0_d [bit_num];
    logic [wordlength-1:0]             min1_q [bit_num];
    logic [wordlength-1:0]             min1_d [bit_num];
    logic signed [LLR_wordlength-1:0]  llr_q [bit_num];
    logic signed [LLR_wordlength-1:0]  llr_d [bit_num];

    logic [2:0]                        mode_eff_s;
    logic [SYM_W-1:0]                  sym_cnt_s;
    logic [2:0]                        bit_cnt_s;
    logic [CNT_W-1:0]                  grp_cnt_s;
    logic [SYM_W-1:0]                  lane_idx_s [LANES];
    logic [wordlength-1:0]             lane_metric_s [LANES];
    logic                              lane_use_s [LANES];
    logic [wordlength-1:0]             grp_min0_s [bit_num];
    logic [wordlength-1:0]             grp_min1_s [bit_num];
    logic signed [LLR_wordlength-1:0]  diff_s [bit_num];
    logic signed [LLR_wordlength-1:0]  llr_val_s [bit_num];

    assign in_ready  = rst_n & (state_q == S_IDLE);
    assign busy      = (state_q == S_SWEEP) | (state_q == S_DONE);
    assign out_valid = out_valid_q;

    for (genvar gk = 0; gk < bit_num; gk++) begin : g_llr_out
        assign llr_bus[gk*LLR_wordlength +: LLR_wordlength] = llr_q[gk];
    end

    // Mode decoding: codes above 4 alias 64APSK; symbol/bit/group counts from the captured mode.
    always_comb begin
        mode_eff_s = (mode > 3'd4) ? 3'd4 : mode;
        sym_cnt_s  = SYM_W'(3'd4) << mode_q;
        bit_cnt_s  = mode_q + 3'd2;
        // Fewer symbols than lanes (QPSK) still needs one sweep cycle.
        grp_cnt_s  = (sym_cnt_s < SYM_W'(LANES)) ? CNT_W'(1)
                                                 : CNT_W'(sym_cnt_s / SYM_W'(LANES));
    end

    // Lane fetch: symbol index, metric and in-constellation flag for each lane of the current group.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx_s[l]    = SYM_W'(cnt_q) * SYM_W'(LANES) + SYM_W'(l);
            lane_metric_s[l] = metric_q[lane_idx_s[l][SW-1:0]];
            lane_use_s[l]    = (lane_idx_s[l] < sym_cnt_s);
        end
    end

    // Group reduction: fold the active lanes into the running per-bit minima.
    always_comb begin
        for (int k = 0; k < bit_num; k++) begin
            grp_min0_s[k] = min0_q[k];
            grp_min1_s[k] = min1_q[k];
            for (int l = 0; l < LANES; l++) begin
                grp_min1_s[k] = (lane_use_s[l] && lane_idx_s[l][k] &&
                                 (lane_metric_s[l] < grp_min1_s[k])) ? lane_metric_s[l]
                                                                     : grp_min1_s[k];
                grp_min0_s[k] = (lane_use_s[l] && !lane_idx_s[l][k] &&
                                 (lane_metric_s[l] < grp_min0_s[k])) ? lane_metric_s[l]
                                                                     : grp_min0_s[k];
            end
        end
    end

    // LLR formation: zero-extended difference, optional saturation, unused bits forced to zero.
    always_comb begin
        for (int k = 0; k < bit_num; k++) begin
            diff_s[k] = LLR_wordlength'(min1_q[k]) - LLR_wordlength'(min0_q[k]);
`ifdef LLR_CLIP_EN
            llr_val_s[k] = (diff_s[k] > CLIP_POS) ? CLIP_POS :
                           (diff_s[k] < CLIP_NEG) ? CLIP_NEG : diff_s[k];
`else
            llr_val_s[k] = diff_s[k];
`endif
            llr_val_s[k] = (3'(k) < bit_cnt_s) ? llr_val_s[k] : '0;
        end
    end

    // Control FSM next-state: accept, sweep groups, one extra cycle to form the LLRs, hold until taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        min0_d      = min0_q;
        min1_d      = min1_q;
        llr_d       = llr_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_SWEEP;
                    cnt_d   = '0;
                    mode_d  = mode_eff_s;
                    for (int k = 0; k < bit_num; k++) begin
                        min0_d[k] = MIN_INIT;
                        min1_d[k] = MIN_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SWEEP: begin
                // cnt_q == group count means every group has been folded in.
                if (cnt_q == grp_cnt_s) begin
                    llr_d       = llr_val_s;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    min0_d = grp_min0_s;
                    min1_d = grp_min1_s;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State, minima and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= 3'd0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < bit_num; k++) begin
                min0_q[k] <= MIN_INIT;
                min1_q[k] <= MIN_INIT;
                llr_q[k]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            min0_q      <= min0_d;
            min1_q      <= min1_d;
            llr_q       <= llr_d;
        end
    end

    // Metric capture on frame acceptance; pure datapath storage, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == S_IDLE) && in_valid) begin
            for (int i = 0; i < sym_num; i++) begin
                metric_q[i] <= metric_bus[i*wordlength +: wordlength];
            end
        end
    end

endmodule

// File: tb/tb_llr_min_search.sv
module tb_llr_min_search;

    localparam int W    = 18;
    localparam int LW   = 19;
    localparam int SN   = 64;
    localparam int BN   = 6;
    localparam int LLRV = BN * LW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        mode = 3'd0;
    logic [SN*W-1:0]   metric_bus = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [LLRV-1:0]   llr_bus;
    logic              busy;

    llr_min_search dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .metric_bus (metric_bus),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .llr_bus    (llr_bus),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LLRV-1:0] llr;
        int              acc;
        int              lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int unsigned cur_m[SN];
    bit          bp_force = 1'b0;
    bit          bp_val = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
    endtask

    // Reference: max-log LLR straight from the definition over all symbols.
    function automatic logic [LLRV-1:0] ref_llr(input int md);
        int e;
        int s;
        longint mn0;
        longint mn1;
        longint d;
        logic [LLRV-1:0] r;
        e = (md > 4) ? 4 : md;
        s = 4 << e;
        r = '0;
        for (int k = 0; k < e + 2; k++) begin
            mn0 = 64'd1 << 40;
            mn1 = 64'd1 << 40;
            for (int i = 0; i < s; i++) begin
                if (((i >> k) & 1) == 1) begin
                    if (cur_m[i] < mn1) mn1 = cur_m[i];
                end else begin
                    if (cur_m[i] < mn0) mn0 = cur_m[i];
                end
            end
            d = mn1 - mn0;
`ifdef LLR_CLIP_EN
            if (d > 65535) d = 65535;
            if (d < -65535) d = -65535;
`endif
            r[k*LW +: LW] = LW'(d);
        end
        return r;
    endfunction

    function automatic int ref_lat(input int md);
        int e;
        int n;
        e = (md > 4) ? 4 : md;
        n = (4 << e) / 8;
        if (n < 1) n = 1;
        return n + 1;
    endfunction

    // Issue one frame from cur_m, wait (bounded) for acceptance, push the expectation.
    task automatic send(input logic [2:0] md);
        exp_t e;
        bit   ok;
        logic r;
        ok = 1'b0;
        @(posedge clk);
        #2;
        mode = md;
        for (int i = 0; i < SN; i++) metric_bus[i*W +: W] = W'(cur_m[i]);
        in_valid = 1'b1;
        e.llr = ref_llr(int'(md));
        e.lat = ref_lat(int'(md));
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        #2;
        in_valid = 1'b0;
        if (ok) begin
            e.acc = cyc;
            sb.push_back(e);
            // Inputs change while the frame is in flight; the captured copy must be used.
            mode = 3'($urandom_range(0, 7));
            for (int i = 0; i < SN; i++) metric_bus[i*W +: W] = W'($urandom);
        end else begin
            fail_now("accept_timeout");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (in_ready && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("idle_timeout");
    endtask

    // Consumer ready: random unless the main sequence forces a level.
    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #2;
            out_ready = bp_force ? bp_val : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on each new result and checks handshake invariants.
    initial begin : monitor
        exp_t            e;
        bit              seen;
        logic [LLRV-1:0] held;
        seen = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else begin
                chk("in_ready_vs_busy", in_ready, !busy);
                if (out_valid) begin
                    chk("busy_in_done", busy, 1);
                    if (!seen) begin
                        if (sb.size() == 0) begin
                            fail_now("unexpected_out");
                        end else begin
                            e = sb.pop_front();
                            for (int k = 0; k < BN; k++)
                                chk($sformatf("llr%0d", k), $signed(llr_bus[k*LW +: LW]),
                                    $signed(e.llr[k*LW +: LW]));
                            chk("latency", cyc - e.acc, e.lat);
                        end
                        held = llr_bus;
                        seen = 1'b1;
                    end else begin
                        chk("llr_hold", (llr_bus == held) ? 1 : 0, 1);
                    end
                    if (out_ready) seen = 1'b0;
                end
            end
        end
    end

    initial begin : main
        bit got;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_llr", (llr_bus == '0) ? 1 : 0, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        #1 rst_n = 1'b1;
        #1 chk("idle_in_ready", in_ready, 1);

        // QPSK: only symbols 0..3 count.
        for (int i = 0; i < SN; i++) cur_m[i] = 5;
        cur_m[0] = 100; cur_m[1] = 200; cur_m[2] = 300; cur_m[3] = 400;
        send(3'd0);
        wait_idle();

        // 64APSK ramp.
        for (int i = 0; i < SN; i++) cur_m[i] = 10 * i + 5;
        send(3'd4);
        wait_idle();

        // Mode 7 aliases 64APSK.
        send(3'd7);
        wait_idle();

        // Backpressure on an 8PSK result.
        for (int i = 0; i < SN; i++) cur_m[i] = i;
        @(posedge clk);
        #1;
        bp_force = 1'b1;
        bp_val = 1'b0;
        send(3'd1);
        got = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("bp_out_valid_timeout");
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #2;
            in_valid = t[0] ? 1'b0 : 1'b1;
            for (int i = 0; i < SN; i++) metric_bus[i*W +: W] = W'($urandom);
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        bp_val = 1'b1;
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        bp_force = 1'b0;
        bp_val = 1'b0;
        wait_idle();

        // Reset during the third 64APSK sweep cycle, then an 8PSK frame.
        for (int i = 0; i < SN; i++) cur_m[i] = 10 * i + 5;
        send(3'd4);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_llr", (llr_bus == '0) ? 1 : 0, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        #1 rst_n = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < SN; i++) cur_m[i] = i;
        send(3'd1);
        wait_idle();

        // 8PSK extremes: most negative LLR on bit 0.
        for (int i = 0; i < SN; i++) cur_m[i] = (i % 2 == 0) ? 262143 : 0;
        send(3'd1);
        wait_idle();

        // Random frames, wide-range then narrow-range metrics (ties).
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < SN; i++)
                cur_m[i] = (f < 15) ? $urandom_range(0, 262143) : $urandom_range(0, 7);
            send(3'($urandom_range(0, 7)));
        end
        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
